lcd_char_receiver: RTL and testbench

Receiving end of the character-LCD byte stream. It samples `lcd_data` on every clock where `lcd_enable` is high and decodes each byte as either a printable character or a control code. Characters go into a ROWS×COLS display buffer at a hardware cursor. The buffer is readable through a registered port, so the display or testbench can check what a driver wrote, and burst and drop statistics are reported.

---
 rtl/lcd_char_receiver.sv | 185 ++++++++++++++++++
 tb/tb_lcd_char_receiver.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_receiver.sv
`default_nettype none
// ============================================================================
// Module      : lcd_char_receiver
// Description : Receiving end of a character-LCD byte stream. Bytes sampled
//               while lcd_enable is high are decoded as printable characters
//               (written at the cursor) or control codes (CR, LF, BS, FF).
//               A ROWS x COLS buffer is cleared by a one-cell-per-clock sweep
//               after reset and on form feed. Burst and drop statistics are
//               reported.
// Ports       : clk, reset      - clock, async active-high reset
//               lcd_data        - byte from the LCD driver
//               lcd_enable      - level strobe, one byte per clock while high
//               rd_addr/rd_data - registered read port (row*COLS+col)
//               cur_row/cur_col - hardware cursor
//               busy            - clear sweep in progress
//               burst_done      - one-cycle pulse after an enable burst ends
//               burst_len       - bytes in last/current burst (saturating)
//               drop_count      - bytes dropped while busy (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_char_receiver #(
  parameter int          COLS  = 16,
  parameter int          ROWS  = 2,
  parameter logic [7:0]  BLANK = 8'h20,
  localparam int DEPTH = ROWS * COLS,
  localparam int AW    = $clog2(DEPTH),
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW    = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    lcd_data,
  input  logic          lcd_enable,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [RW-1:0] cur_row,
  output logic [CW-1:0] cur_col,
  output logic          busy,
  output logic          burst_done,
  output logic [7:0]    burst_len,
  output logic [7:0]    drop_count
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   sweep_addr, sweep_addr_nxt;
  logic [RW-1:0]   row, row_nxt, row_inc;
  logic [CW-1:0]   col, col_nxt;
  logic [AW-1:0]   cell_addr;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      wdata;
  logic            prev_en;
  logic            is_printable;

  logic [7:0]      mem [DEPTH];

  // With a single row the row index is constant zero and the cell address
  // is just the column.
  generate
    if (ROWS > 1) begin : g_multi_row
      assign cell_addr = {row, col};
      assign row_inc   = row + 1'b1;
    end else begin : g_single_row
      assign cell_addr = AW'(col);
      assign row_inc   = '0;
    end
  endgenerate

  assign is_printable = (lcd_data >= 8'h20) && (lcd_data <= 8'h7E);
  assign busy         = (state == ST_SWEEP);
  assign cur_row      = row;
  assign cur_col      = col;

  // --------------------------------------------------------------------------
  // Control FSM: state, sweep pointer and cursor
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_SWEEP;
      sweep_addr <= '0;
      row        <= '0;
      col        <= '0;
    end else begin
      state      <= state_nxt;
      sweep_addr <= sweep_addr_nxt;
      row        <= row_nxt;
      col        <= col_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sweep_addr_nxt = sweep_addr;
    row_nxt        = row;
    col_nxt        = col;
    we             = 1'b0;
    waddr          = cell_addr;
    wdata          = lcd_data;
    if (state == ST_SWEEP) begin
      // Incoming bytes are ignored here; they only feed the drop counter.
      we             = 1'b1;
      waddr          = sweep_addr;
      wdata          = BLANK;
      sweep_addr_nxt = sweep_addr + 1'b1;
      if (sweep_addr == LAST_ADDR) begin
        state_nxt = ST_IDLE;
      end
    end else if (lcd_enable) begin
      if (is_printable) begin
        we = 1'b1;
        if (col == LAST_COL) begin
          col_nxt = '0;
          row_nxt = row_inc;
        end else begin
          col_nxt = col + 1'b1;
        end
      end else begin
        case (lcd_data)
          8'h0D: col_nxt = '0;
          8'h0A: row_nxt = row_inc;
          8'h08: if (col != '0) col_nxt = col - 1'b1;
          8'h0C: begin
            row_nxt        = '0;
            col_nxt        = '0;
            sweep_addr_nxt = '0;
            state_nxt      = ST_SWEEP;
          end
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Display buffer: single write port, registered read-before-write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Burst and drop statistics; every sampled byte counts, decoded or not
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_en    <= 1'b0;
      burst_done <= 1'b0;
      burst_len  <= 8'h00;
      drop_count <= 8'h00;
    end else begin
      prev_en    <= lcd_enable;
      burst_done <= !lcd_enable && prev_en;
      if (lcd_enable) begin
        if (!prev_en) begin
          burst_len <= 8'd1;
        end else if (burst_len != 8'hFF) begin
          burst_len <= burst_len + 8'd1;
        end
        if (busy && (drop_count != 8'hFF)) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_char_receiver
// Description : Directed self-checking bench for lcd_char_receiver with the
//               default 2 x 16 geometry. Inputs change and outputs are
//               observed on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_char_receiver;

  logic       clk;
  logic       reset;
  logic [7:0] lcd_data;
  logic       lcd_enable;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [0:0] cur_row;
  logic [3:0] cur_col;
  logic       busy;
  logic       burst_done;
  logic [7:0] burst_len;
  logic [7:0] drop_count;

  int checks   = 0;
  int failures = 0;

  lcd_char_receiver #(
    .COLS  (16),
    .ROWS  (2),
    .BLANK (8'h20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .lcd_data   (lcd_data),
    .lcd_enable (lcd_enable),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .busy       (busy),
    .burst_done (burst_done),
    .burst_len  (burst_len),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one byte; returns at the falling edge after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    lcd_enable = 1'b1;
    lcd_data   = b;
    @(negedge clk);
  endtask

  task automatic go_idle(input int n);
    lcd_enable = 1'b0;
    lcd_data   = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic read_cell(input logic [4:0] a, output logic [7:0] d);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    lcd_enable = 1'b0;
    lcd_data   = 8'h00;
    rd_addr    = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_data, cur_row, cur_col, busy, burst_done, burst_len, drop_count} !==
        {8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL reset_values: got rd=%h row=%0d col=%0d busy=%b done=%b len=%0d drop=%0d expected rd=00 row=0 col=0 busy=1 done=0 len=0 drop=0",
               rd_data, cur_row, cur_col, busy, burst_done, burst_len, drop_count);
    end
  endtask

  task automatic test_sweep_after_reset;
    int busy_cycles;
    logic [7:0] d;
    busy_cycles = 0;
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    checks++;
    if (busy_cycles !== 32) begin
      failures++;
      $display("FAIL sweep_busy_cycles: got %0d expected 32", busy_cycles);
    end
    checks++;
    if (drop_count !== 8'd0) begin
      failures++;
      $display("FAIL sweep_drop_count: got %0d expected 0", drop_count);
    end
    for (int a = 0; a < 32; a++) begin
      read_cell(5'(a), d);
      checks++;
      if (d !== 8'h20) begin
        failures++;
        $display("FAIL sweep_cell_%0d: got %h expected 20", a, d);
      end
    end
  endtask

  task automatic test_hello;
    logic [7:0] msg [5];
    logic [7:0] d;
    int extra;
    msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    for (int i = 0; i < 5; i++) send_byte(msg[i]);
    lcd_enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({burst_done, burst_len} !== {1'b1, 8'd5}) begin
      failures++;
      $display("FAIL hello_burst_done: got done=%b len=%0d expected done=1 len=5", burst_done, burst_len);
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (burst_done) extra++;
    end
    checks++;
    if ({extra, burst_len} !== {32'd0, 8'd5}) begin
      failures++;
      $display("FAIL hello_single_pulse: got extra=%0d len=%0d expected extra=0 len=5", extra, burst_len);
    end
    checks++;
    if ({cur_row, cur_col} !== {1'b0, 4'd5}) begin
      failures++;
      $display("FAIL hello_cursor: got (%0d,%0d) expected (0,5)", cur_row, cur_col);
    end
    for (int i = 0; i < 6; i++) begin
      read_cell(5'(i), d);
      checks++;
      if (d !== ((i < 5) ? msg[i] : 8'h20)) begin
        failures++;
        $display("FAIL hello_cell_%0d: got %h expected %h", i, d, (i < 5) ? msg[i] : 8'h20);
      end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] d;
    logic [4:0] addrs [4];
    logic [7:0] expv  [4];
    send_byte(8'h0D);
    for (int i = 0; i < 33; i++) send_byte(8'h41);
    go_idle(2);
    checks++;
    if ({cur_row, cur_col} !== {1'b0, 4'd1}) begin
      failures++;
      $display("FAIL wrap33_cursor: got (%0d,%0d) expected (0,1)", cur_row, cur_col);
    end
    addrs = '{5'd0, 5'd15, 5'd16, 5'd31};
    for (int i = 0; i < 4; i++) begin
      read_cell(addrs[i], d);
      checks++;
      if (d !== 8'h41) begin
        failures++;
        $display("FAIL wrap33_cell_%0d: got %h expected 41", addrs[i], d);
      end
    end
    send_byte(8'h0D);
    for (int i = 0; i < 17; i++) send_byte(8'h42);
    go_idle(2);
    checks++;
    if ({cur_row, cur_col} !== {1'b1, 4'd1}) begin
      failures++;
      $display("FAIL wrap17_cursor: got (%0d,%0d) expected (1,1)", cur_row, cur_col);
    end
    addrs = '{5'd0, 5'd15, 5'd16, 5'd17};
    expv  = '{8'h42, 8'h42, 8'h42, 8'h41};
    for (int i = 0; i < 4; i++) begin
      read_cell(addrs[i], d);
      checks++;
      if (d !== expv[i]) begin
        failures++;
        $display("FAIL wrap17_cell_%0d: got %h expected %h", addrs[i], d, expv[i]);
      end
    end
  endtask

  task automatic test_controls;
    logic [7:0] codes [7];
    logic [4:0] exp_pos [7];
    logic [7:0] d;
    // From (1,1): LF wraps row to 0, CR, then three characters give (0,3).
    send_byte(8'h0A);
    send_byte(8'h0D);
    send_byte(8'h43);
    send_byte(8'h44);
    send_byte(8'h45);
    checks++;
    if ({cur_row, cur_col} !== {1'b0, 4'd3}) begin
      failures++;
      $display("FAIL ctrl_setup_cursor: got (%0d,%0d) expected (0,3)", cur_row, cur_col);
    end
    codes   = '{8'h0D, 8'h08, 8'h0A, 8'h5A, 8'h01, 8'h7F, 8'h08};
    exp_pos = '{{1'b0, 4'd0}, {1'b0, 4'd0}, {1'b1, 4'd0}, {1'b1, 4'd1},
                {1'b1, 4'd1}, {1'b1, 4'd1}, {1'b1, 4'd0}};
    for (int i = 0; i < 7; i++) begin
      send_byte(codes[i]);
      checks++;
      if ({cur_row, cur_col} !== exp_pos[i]) begin
        failures++;
        $display("FAIL ctrl_code_%h_step%0d: got (%0d,%0d) expected (%0d,%0d)",
                 codes[i], i, cur_row, cur_col, exp_pos[i][4], exp_pos[i][3:0]);
      end
    end
    go_idle(1);
    read_cell(5'd16, d);
    checks++;
    if (d !== 8'h5A) begin
      failures++;
      $display("FAIL ctrl_cell_16: got %h expected 5a", d);
    end
    read_cell(5'd17, d);
    checks++;
    if (d !== 8'h41) begin
      failures++;
      $display("FAIL ctrl_cell_17: got %h expected 41", d);
    end
    read_cell(5'd2, d);
    checks++;
    if (d !== 8'h45) begin
      failures++;
      $display("FAIL ctrl_cell_2: got %h expected 45", d);
    end
  endtask

  task automatic test_clear_drop;
    int busy_cycles;
    logic [7:0] d;
    logic [4:0] addrs [5];
    logic [7:0] expv  [5];
    busy_cycles = 0;
    send_byte(8'h0C);
    if (busy) busy_cycles++;
    for (int i = 0; i < 34; i++) begin
      send_byte(8'h41);
      if (busy) busy_cycles++;
    end
    lcd_enable = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_cycles !== 32) begin
      failures++;
      $display("FAIL clear_busy_cycles: got %0d expected 32", busy_cycles);
    end
    checks++;
    if (drop_count !== 8'd32) begin
      failures++;
      $display("FAIL clear_drop_count: got %0d expected 32", drop_count);
    end
    checks++;
    if ({burst_done, burst_len} !== {1'b1, 8'd35}) begin
      failures++;
      $display("FAIL clear_burst: got done=%b len=%0d expected done=1 len=35", burst_done, burst_len);
    end
    checks++;
    if ({cur_row, cur_col} !== {1'b0, 4'd2}) begin
      failures++;
      $display("FAIL clear_cursor: got (%0d,%0d) expected (0,2)", cur_row, cur_col);
    end
    addrs = '{5'd0, 5'd1, 5'd2, 5'd16, 5'd31};
    expv  = '{8'h41, 8'h41, 8'h20, 8'h20, 8'h20};
    for (int i = 0; i < 5; i++) begin
      read_cell(addrs[i], d);
      checks++;
      if (d !== expv[i]) begin
        failures++;
        $display("FAIL clear_cell_%0d: got %h expected %h", addrs[i], d, expv[i]);
      end
    end
  endtask

  task automatic test_reset_mid_sweep;
    int busy_cycles;
    int done_pulses;
    logic [7:0] d;
    send_byte(8'h0C);
    for (int i = 0; i < 9; i++) send_byte(8'h41);
    reset      = 1'b1;
    lcd_enable = 1'b0;
    lcd_data   = 8'h00;
    #1;
    checks++;
    if ({rd_data, cur_row, cur_col, busy, burst_done, burst_len, drop_count} !==
        {8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL midreset_async_values: got rd=%h row=%0d col=%0d busy=%b done=%b len=%0d drop=%0d expected rd=00 row=0 col=0 busy=1 done=0 len=0 drop=0",
               rd_data, cur_row, cur_col, busy, burst_done, burst_len, drop_count);
    end
    repeat (2) @(negedge clk);
    reset       = 1'b0;
    busy_cycles = 0;
    done_pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cycles++;
      if (burst_done) done_pulses++;
      @(negedge clk);
    end
    checks++;
    if (busy_cycles !== 32) begin
      failures++;
      $display("FAIL midreset_busy_cycles: got %0d expected 32", busy_cycles);
    end
    checks++;
    if (done_pulses !== 0) begin
      failures++;
      $display("FAIL midreset_burst_done: got %0d pulses expected 0", done_pulses);
    end
    read_cell(5'd31, d);
    checks++;
    if (d !== 8'h20) begin
      failures++;
      $display("FAIL midreset_cell_31: got %h expected 20", d);
    end
  endtask

  initial begin
    test_reset();
    test_sweep_after_reset();
    test_hello();
    test_wrap();
    test_controls();
    test_clear_drop();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
